// File: rtl/branch_resolution_queue.sv
// rtl/branch_resolution_queue.sv - in-order branch prediction queue with resolve/mispredict handling; optional stats via BRQ_STATS_EN
module branch_resolution_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic             push_taken,
    output logic             push_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic             update_enable,
    output logic             actual_taken,
    output logic             mispredict,
    output logic             flush,
    output logic [PTR_W:0]   occupancy
`ifdef BRQ_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] taken_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_fire;
    logic             resolve_fire;
    logic             mis_now;

    // A mispredict or its flush cycle blocks pushes so wrong-path entries never land
    always_comb begin
        resolve_ready = (occupancy != '0);
        resolve_fire  = resolve_valid && resolve_ready;
        mis_now       = resolve_fire && (taken_q[rd_ptr] != resolve_taken);
        push_ready    = (occupancy != OCC_FULL) && !mis_now && !flush;
        push_fire     = push_valid && push_ready;
    end

    // Prediction storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (push_fire) begin
            taken_q[wr_ptr] <= push_taken;
        end
    end

    // Pointer/occupancy bookkeeping; a mispredict empties the queue in the resolve cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (mis_now) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (resolve_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_fire, resolve_fire})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Registered predictor-update and flush pulses, one cycle after a resolve fires
    always_ff @(posedge clk) begin
        if (rst) begin
            update_enable <= 1'b0;
            actual_taken  <= 1'b0;
            mispredict    <= 1'b0;
            flush         <= 1'b0;
        end else begin
            update_enable <= resolve_fire;
            mispredict    <= mis_now;
            flush         <= mis_now;
            if (resolve_fire) begin
                actual_taken <= resolve_taken;
            end
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating statistics, counted on the update pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (update_enable) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end
`else
    // Counter width only matters when statistics are built in
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule
